// File: rtl/io_output_arbiter.sv
// io_output_arbiter: round-robin arbiter that shares one UART transmit path
// between REQ_COUNT byte requesters.
// A grant stays locked on one requester until the last byte of its packet has
// been shifted out, so packets from different requesters never interleave.
// Optional build macro IO_ARB_LOCK_TIMEOUT_EN adds a stall timeout that
// releases a lock whose owner stops presenting bytes. When it is enabled, the
// lock_timeout_pulse port is also present.
module io_output_arbiter #(
  parameter int REQ_COUNT    = 4,
  parameter int IDX_W        = $clog2(REQ_COUNT),
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REQ_COUNT-1:0]   req_valid,
  input  logic [8*REQ_COUNT-1:0] req_value,
  input  logic [REQ_COUNT-1:0]   req_last,
  output logic [REQ_COUNT-1:0]   req_ready,
  output logic                   io_output_trigger,
  output logic [7:0]             io_output_value,
  input  logic                   io_output_busy,
  output logic                   grant_active,
  output logic [IDX_W-1:0]       grant_index
`ifdef IO_ARB_LOCK_TIMEOUT_EN
  ,
  output logic                   lock_timeout_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] grant_index_reg;
  logic             grant_active_reg;
  logic             last_reg;
  logic             trigger_reg;
  logic [7:0]       value_reg;

  // Candidate order for the round-robin search: rr_ptr, rr_ptr+1, ... (mod N)
  logic [IDX_W-1:0] cand_idx [REQ_COUNT];

  genvar gi;
  generate
    for (gi = 0; gi < REQ_COUNT; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(rr_ptr_reg) + gi) % REQ_COUNT);
    end
  endgenerate

  // Pick the first valid requester at or after rr_ptr; scanning from the far
  // end lets the nearest candidate overwrite the others.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = REQ_COUNT - 1; off >= 0; off--) begin
      if (req_valid[cand_idx[off]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[off];
      end
    end
  end

  // The handshake is only visible to the locked requester while in ISSUE.
  generate
    for (gi = 0; gi < REQ_COUNT; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ISSUE) &&
                             (grant_index_reg == IDX_W'(gi));
    end
  endgenerate

  // Byte currently offered by the lock holder
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_value;
  assign g_valid = req_valid[grant_index_reg];
  assign g_last  = req_last[grant_index_reg];
  assign g_value = req_value[{grant_index_reg, 3'b000} +: 8];

  // Priority moves to the requester just after the one being released
  logic [IDX_W-1:0] next_ptr;
  assign next_ptr = (grant_index_reg == IDX_W'(REQ_COUNT - 1)) ? '0
                    : grant_index_reg + IDX_W'(1);

`ifdef IO_ARB_LOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_pulse_reg;
`endif

  // Arbitration FSM: lock a requester, forward its bytes one at a time and
  // follow the TX controller's busy envelope for each byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= '0;
      grant_index_reg  <= '0;
      grant_active_reg <= 1'b0;
      last_reg         <= 1'b0;
      trigger_reg      <= 1'b0;
      value_reg        <= 8'h00;
`ifdef IO_ARB_LOCK_TIMEOUT_EN
      tmo_cnt_reg      <= '0;
      tmo_pulse_reg    <= 1'b0;
`endif
    end else begin
      trigger_reg <= 1'b0;
`ifdef IO_ARB_LOCK_TIMEOUT_EN
      tmo_pulse_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
`ifdef IO_ARB_LOCK_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          if (pick_found) begin
            grant_index_reg  <= pick_idx;
            grant_active_reg <= 1'b1;
            state_reg        <= ISSUE;
          end
        end

        ISSUE: begin
          if (g_valid) begin
            value_reg   <= g_value;
            last_reg    <= g_last;
            trigger_reg <= 1'b1;
            state_reg   <= WAIT_BUSY;
`ifdef IO_ARB_LOCK_TIMEOUT_EN
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg == TMO_W'(LOCK_TIMEOUT - 1)) begin
            // Owner has been silent for LOCK_TIMEOUT cycles: drop the lock
            grant_active_reg <= 1'b0;
            rr_ptr_reg       <= next_ptr;
            tmo_cnt_reg      <= '0;
            tmo_pulse_reg    <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
`endif
          end
        end

        WAIT_BUSY: begin
          // Busy raised in the trigger cycle itself is taken here as well
          if (io_output_busy) begin
            state_reg <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (!io_output_busy) begin
            if (last_reg) begin
              grant_active_reg <= 1'b0;
              rr_ptr_reg       <= next_ptr;
              state_reg        <= IDLE;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io_output_trigger = trigger_reg;
  assign io_output_value   = value_reg;
  assign grant_active      = grant_active_reg;
  assign grant_index       = grant_index_reg;
`ifdef IO_ARB_LOCK_TIMEOUT_EN
  assign lock_timeout_pulse = tmo_pulse_reg;
`endif

endmodule
